cal_comparator_argmax_pipe: RTL and testbench
=============================================

Name: cal_comparator_argmax_pipe

Overview:
- Parametrised, pipelined multi-lane argmax engine for the yolo_layer class-score path.
- Each lane finds the maximum element and its index over ELEMS packed scores per beat.
- Running max is accumulated over BEATS consecutive beats, so class counts above ELEMS are covered.
- Registered compare tree plus a result accumulator.
- Drives downstream box/class selection with an out_valid strobe.

Parameters:
- LANES, 5, number of independent lanes (channels).
- ELEMS, 8, elements per lane per beat; power of two, >=2.
- DW, 8, element width in bits.
- SIGNED, 0, 1 = compare as two's complement; 0 = unsigned.
- BEATS, 1, beats merged into one result per lane; >=1.
- IW (derived), clog2(ELEMS*BEATS) (minimum 1), index width.
- S (derived), clog2(ELEMS), compare-tree stages.

Ports:
- clk  input  1  clock; all state on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- yolo_layer_finish  input  1  synchronous flush: clears beat counter, accumulators, and all pipeline valids.
- in_valid  input  1  data_i carries a beat this cycle. No backpressure: a beat is accepted every valid cycle.
- data_i  input  LANES*ELEMS*DW  lane l element e at bits [(l*ELEMS+e)*DW +: DW].
- out_valid  output  1  one-cycle pulse; a result is valid.
- max_value  output  LANES*DW  lane l max at [l*DW +: DW].
- max_index  output  LANES*IW  lane l index at [l*IW +: IW]. Index = beat_no*ELEMS + e.

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0, max_value=0, max_index=0. Beat counter=0, all stage valids=0, accumulators cleared.
- Tree: S registered stages of pairwise compare.
  - The winner carries its value and local index (clog2(ELEMS) bits).
  - Replacement is by strict greater-than only, so on a tie the lower index wins at every level.
  - Compare is signed when SIGNED=1, unsigned otherwise.
- Beat tagging: the beat number (0..BEATS-1) travels with the valid through the tree.
  - Full index = beat_no*ELEMS + local_index, computed in IW bits with no overflow by construction.
- Accumulator stage (one register):
  - On a tree-output valid with beat_no=0, the accumulator loads the tree result.
  - Otherwise it replaces only if tree value > accumulator value (strict), so earlier beats win ties.
  - On beat_no=BEATS-1, the merged value is registered to max_value/max_index and out_valid pulses for 1 cycle.
- Latency: out_valid rises S+1 cycles after the in_valid of the final beat. The default ELEMS=8 gives 4 cycles.
- Throughput: with back-to-back beats, one result every BEATS cycles.
- max_value/max_index hold their last result when out_valid=0.
- Beat counter:
  - Increments on each accepted beat and wraps from BEATS-1 to 0.
  - With BEATS=1 it is constant 0 and every beat produces a result.
- Gaps: in_valid may deassert between the beats of a group. The counter and accumulator hold across idle cycles.
- yolo_layer_finish=1 (synchronous, highest priority):
  - Clears the beat counter, every stage valid, and the accumulator.
  - A beat presented in the same cycle is discarded.
  - No out_valid is produced for any partially accumulated group or for in-flight beats.
  - max_value/max_index keep their last completed result.
- Reset asserted mid-group: everything returns to reset values immediately; no output pulse follows.
- BEATS=1 and ELEMS=2: S=1 and latency is 2.

Test Plan:
- Defaults, lane1 elems = {3,9,1,9,0,0,0,0} (e0 first), other lanes 0, one beat -> 4 cycles later out_valid=1 for 1 cycle, lane1 max=9 idx=1 (tie picks lower), other lanes max=0 idx=0.
- SIGNED=1, lane0 = {0x80,0xFF,0x81,...all 0x90} -> max=0xFF (-1) idx=1. SIGNED=0 with the same data -> max=0xFF idx=1; with 0xFF replaced by 0x7F -> unsigned max=0x90 idx=3.
- BEATS=3, ELEMS=8, lane0 beat0 max 20@e5, beat1 max 50@e2, beat2 max 50@e7 -> single out_valid after beat2 + 4 cycles, value=50, index=10 (beat1 wins tie).
- Back-to-back beats for 16 cycles, BEATS=1 -> 16 consecutive out_valid pulses, each matching a scoreboard model, no bubbles.
- BEATS=3, two beats sent, then yolo_layer_finish pulsed together with a third beat -> no out_valid, outputs hold old result. A fresh 3-beat group afterwards produces the correct result with indices restarting at beat 0.
- rst driven low asynchronously mid-pipeline (no clock edge) -> outputs and out_valid go 0 immediately, and no pulse appears after release.

Source files
------------

// File: rtl/cal_comparator_argmax_pipe_if.sv
`default_nettype none
// ============================================================================
// Module : cal_comparator_argmax_pipe_if
// Brief  : Beat-in / result-out bundle for the pipelined argmax engine.
// Rev    : 1.0  initial release
// ============================================================================
interface cal_comparator_argmax_pipe_if #(
    parameter int LANES = 5,
    parameter int ELEMS = 8,
    parameter int DW    = 8,
    parameter int BEATS = 1
);
    localparam int IW = (ELEMS * BEATS > 1) ? $clog2(ELEMS * BEATS) : 1;

    logic                        yolo_layer_finish;
    logic                        in_valid;
    logic [LANES*ELEMS*DW-1:0]   data_i;
    logic                        out_valid;
    logic [LANES*DW-1:0]         max_value;
    logic [LANES*IW-1:0]         max_index;

    modport master (
        output yolo_layer_finish,
        output in_valid,
        output data_i,
        input  out_valid,
        input  max_value,
        input  max_index
    );

    modport slave (
        input  yolo_layer_finish,
        input  in_valid,
        input  data_i,
        output out_valid,
        output max_value,
        output max_index
    );
endinterface
`default_nettype wire

// File: rtl/cal_comparator_argmax_pipe.sv
`default_nettype none
// ============================================================================
// Module : cal_comparator_argmax_pipe
// Brief  : Multi-lane registered compare tree with a per-lane running-max
//          accumulator merging BEATS beats into one (value, index) result.
// Rev    : 1.0  initial release
// ============================================================================
module cal_comparator_argmax_pipe #(
    parameter int LANES  = 5,
    parameter int ELEMS  = 8,
    parameter int DW     = 8,
    parameter int SIGNED = 0,
    parameter int BEATS  = 1
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    cal_comparator_argmax_pipe_if.slave  bus
);

    localparam int IW = (ELEMS * BEATS > 1) ? $clog2(ELEMS * BEATS) : 1;
    localparam int S  = $clog2(ELEMS);
    localparam int LW = S;
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    function automatic logic gt(input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (SIGNED != 0) return $signed(a) > $signed(b);
        else             return a > b;
    endfunction

    // ------------------------------------------------------------------
    // Leaves and beat counter
    // ------------------------------------------------------------------
    logic [DW-1:0] w_leaf_val [LANES][ELEMS];
    logic [BW-1:0] beat_q, beat_d;
    logic          w_accept;

    assign w_accept = bus.in_valid & ~bus.yolo_layer_finish;

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            for (int e = 0; e < ELEMS; e++) begin
                w_leaf_val[l][e] = bus.data_i[(l*ELEMS+e)*DW +: DW];
            end
        end
    end

    always_comb begin
        beat_d = beat_q;
        if (bus.yolo_layer_finish) begin
            beat_d = '0;
        end else if (bus.in_valid) begin
            beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Compare tree: stage k holds ELEMS>>(k+1) winners per lane
    // ------------------------------------------------------------------
    logic [DW-1:0] tree_val_q [S][LANES][ELEMS/2];
    logic [LW-1:0] tree_idx_q [S][LANES][ELEMS/2];
    logic [S-1:0]  vld_q;
    logic [BW-1:0] tag_q [S];

    // Strict greater-than on the odd input keeps the lower index on ties.
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            for (int n = 0; n < ELEMS / 2; n++) begin
                if (gt(w_leaf_val[l][2*n+1], w_leaf_val[l][2*n])) begin
                    tree_val_q[0][l][n] <= w_leaf_val[l][2*n+1];
                    tree_idx_q[0][l][n] <= LW'(2*n+1);
                end else begin
                    tree_val_q[0][l][n] <= w_leaf_val[l][2*n];
                    tree_idx_q[0][l][n] <= LW'(2*n);
                end
            end
        end
        for (int k = 1; k < S; k++) begin
            for (int l = 0; l < LANES; l++) begin
                for (int n = 0; n < (ELEMS >> (k + 1)); n++) begin
                    if (gt(tree_val_q[k-1][l][2*n+1], tree_val_q[k-1][l][2*n])) begin
                        tree_val_q[k][l][n] <= tree_val_q[k-1][l][2*n+1];
                        tree_idx_q[k][l][n] <= tree_idx_q[k-1][l][2*n+1];
                    end else begin
                        tree_val_q[k][l][n] <= tree_val_q[k-1][l][2*n];
                        tree_idx_q[k][l][n] <= tree_idx_q[k-1][l][2*n];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_q <= '0;
            vld_q  <= '0;
            for (int k = 0; k < S; k++) tag_q[k] <= '0;
        end else begin
            beat_q   <= beat_d;
            vld_q[0] <= w_accept;
            tag_q[0] <= beat_q;
            for (int k = 1; k < S; k++) begin
                vld_q[k] <= vld_q[k-1] & ~bus.yolo_layer_finish;
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Accumulator and result register
    // ------------------------------------------------------------------
    logic          w_tree_vld;
    logic [BW-1:0] w_tree_tag;
    logic [DW-1:0] w_merge_val [LANES];
    logic [IW-1:0] w_merge_idx [LANES];
    logic [DW-1:0] acc_val_q   [LANES];
    logic [IW-1:0] acc_idx_q   [LANES];
    logic                  out_valid_q;
    logic [LANES*DW-1:0]   max_val_q;
    logic [LANES*IW-1:0]   max_idx_q;

    assign w_tree_vld = vld_q[S-1];
    assign w_tree_tag = tag_q[S-1];

    // Beat 0 always loads; later beats need a strict win, so earlier beats keep ties.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_merge_val[l] = acc_val_q[l];
            w_merge_idx[l] = acc_idx_q[l];
            if ((w_tree_tag == '0) || gt(tree_val_q[S-1][l][0], acc_val_q[l])) begin
                w_merge_val[l] = tree_val_q[S-1][l][0];
                w_merge_idx[l] = IW'({w_tree_tag, tree_idx_q[S-1][l][0]});
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            max_val_q   <= '0;
            max_idx_q   <= '0;
            for (int l = 0; l < LANES; l++) begin
                acc_val_q[l] <= '0;
                acc_idx_q[l] <= '0;
            end
        end else if (bus.yolo_layer_finish) begin
            out_valid_q <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                acc_val_q[l] <= '0;
                acc_idx_q[l] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            if (w_tree_vld) begin
                for (int l = 0; l < LANES; l++) begin
                    acc_val_q[l] <= w_merge_val[l];
                    acc_idx_q[l] <= w_merge_idx[l];
                end
                if (w_tree_tag == LAST_BEAT) begin
                    out_valid_q <= 1'b1;
                    for (int l = 0; l < LANES; l++) begin
                        max_val_q[l*DW +: DW] <= w_merge_val[l];
                        max_idx_q[l*IW +: IW] <= w_merge_idx[l];
                    end
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.max_value = max_val_q;
    assign bus.max_index = max_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_cal_comparator_argmax_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_cal_comparator_argmax_pipe
// Brief  : Scoreboard bench: unsigned single-beat instance and signed 3-beat instance.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cal_comparator_argmax_pipe;
    localparam int LANES = 5;
    localparam int ELEMS = 8;
    localparam int DW    = 8;
    localparam int DWID  = LANES * ELEMS * DW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    cal_comparator_argmax_pipe_if #(.LANES(LANES), .ELEMS(ELEMS), .DW(DW), .BEATS(1)) if_a ();
    cal_comparator_argmax_pipe_if #(.LANES(LANES), .ELEMS(ELEMS), .DW(DW), .BEATS(3)) if_b ();

    cal_comparator_argmax_pipe #(.LANES(LANES), .ELEMS(ELEMS), .DW(DW), .SIGNED(0), .BEATS(1)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    cal_comparator_argmax_pipe #(.LANES(LANES), .ELEMS(ELEMS), .DW(DW), .SIGNED(1), .BEATS(3)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    typedef struct {
        logic [39:0] v;
        logic [24:0] ix;
        int          c;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: pop one expectation per out_valid pulse
    always @(negedge clk) begin
        exp_t e;
        if (if_a.out_valid === 1'b1) begin
            if (q_a.size() == 0) begin
                cmp("a unexpected out_valid", {63'd0, if_a.out_valid}, 64'd0);
            end else begin
                e = q_a.pop_front();
                cmp("a max_value", {24'd0, if_a.max_value}, {24'd0, e.v});
                cmp("a max_index", {49'd0, if_a.max_index}, {39'd0, e.ix});
                cmp("a latency", 64'(cyc), 64'(e.c));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (if_b.out_valid === 1'b1) begin
            if (q_b.size() == 0) begin
                cmp("b unexpected out_valid", {63'd0, if_b.out_valid}, 64'd0);
            end else begin
                e = q_b.pop_front();
                cmp("b max_value", {24'd0, if_b.max_value}, {24'd0, e.v});
                cmp("b max_index", {39'd0, if_b.max_index}, {39'd0, e.ix});
                cmp("b latency", 64'(cyc), 64'(e.c));
            end
        end
    end

    task automatic drive(input bit sel_b, input bit vld, input bit fin, input logic [DWID-1:0] d);
        @(posedge clk);
        #1;
        if_a.in_valid = 1'b0; if_a.yolo_layer_finish = 1'b0; if_a.data_i = '0;
        if_b.in_valid = 1'b0; if_b.yolo_layer_finish = 1'b0; if_b.data_i = '0;
        if (sel_b) begin
            if_b.in_valid = vld; if_b.yolo_layer_finish = fin; if_b.data_i = d;
        end else begin
            if_a.in_valid = vld; if_a.yolo_layer_finish = fin; if_a.data_i = d;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic push_a(input logic [39:0] v, input logic [24:0] ix);
        q_a.push_back('{v: v, ix: ix, c: cyc + 4});
    endtask

    task automatic push_b(input logic [39:0] v, input logic [24:0] ix);
        q_b.push_back('{v: v, ix: ix, c: cyc + 4});
    endtask

    // elems packed e7..e0, e0 in the low byte
    function automatic logic [DWID-1:0] lane(input int l, input logic [63:0] elems);
        logic [DWID-1:0] r;
        r = '0;
        r[l*64 +: 64] = elems;
        return r;
    endfunction

    // Linear-scan unsigned argmax, first occurrence wins
    function automatic void ref_a(input logic [DWID-1:0] d, output logic [39:0] v, output logic [24:0] ix);
        logic [7:0] best;
        int         bi;
        v  = '0;
        ix = '0;
        for (int l = 0; l < LANES; l++) begin
            best = d[(l*ELEMS)*DW +: DW];
            bi   = 0;
            for (int e = 1; e < ELEMS; e++) begin
                if (d[(l*ELEMS+e)*DW +: DW] > best) begin
                    best = d[(l*ELEMS+e)*DW +: DW];
                    bi   = e;
                end
            end
            v[l*8 +: 8]  = best;
            ix[l*3 +: 3] = bi[2:0];
        end
    endfunction

    initial begin
        logic [DWID-1:0] d;
        logic [39:0]     v;
        logic [24:0]     ix;
        logic [39:0]     last_v;

        if_a.in_valid = 1'b0; if_a.yolo_layer_finish = 1'b0; if_a.data_i = '0;
        if_b.in_valid = 1'b0; if_b.yolo_layer_finish = 1'b0; if_b.data_i = '0;
        last_v = '0;

        repeat (3) @(posedge clk);
        #1;
        cmp("a reset out_valid", {63'd0, if_a.out_valid}, 64'd0);
        cmp("a reset max_value", {24'd0, if_a.max_value}, 64'd0);
        cmp("a reset max_index", {49'd0, if_a.max_index}, 64'd0);
        cmp("b reset out_valid", {63'd0, if_b.out_valid}, 64'd0);
        cmp("b reset max_value", {24'd0, if_b.max_value}, 64'd0);
        rst = 1'b1;
        idle(2);

        // Lane1 {3,9,1,9,0,0,0,0}: tie at 9 resolves to e1
        drive(1'b0, 1'b1, 1'b0, lane(1, 64'h00000000_09010903));
        push_a(40'h00_0000_0900, 25'd8);
        // Unsigned: 0xFF at e1, then 0x7F variant gives 0x90 at e3
        drive(1'b0, 1'b1, 1'b0, lane(0, 64'h90909090_9081FF80));
        push_a(40'h00_0000_00FF, 25'd1);
        drive(1'b0, 1'b1, 1'b0, lane(0, 64'h90909090_90817F80));
        push_a(40'h00_0000_0090, 25'd3);
        idle(6);

        // Back-to-back stream, odd iterations squeezed to few values to force ties
        for (int i = 0; i < 16; i++) begin
            for (int w = 0; w < DWID / 32; w++) d[w*32 +: 32] = $urandom;
            if (i % 2 == 1) d = d & {(DWID/8){8'h83}};
            ref_a(d, v, ix);
            drive(1'b0, 1'b1, 1'b0, d);
            push_a(v, ix);
            last_v = v;
        end
        idle(6);

        // Finish kills an in-flight beat and one presented alongside it
        drive(1'b0, 1'b1, 1'b0, lane(0, 64'hEE));
        drive(1'b0, 1'b1, 1'b1, lane(2, 64'hEE));
        idle(6);
        cmp("a hold after finish", {24'd0, if_a.max_value}, {24'd0, last_v});

        // Signed 3-beat groups: beat0 wins with -1, then with +127
        drive(1'b1, 1'b1, 1'b0, lane(0, 64'h90909090_9081FF80));
        drive(1'b1, 1'b1, 1'b0, lane(0, {8{8'h80}}));
        drive(1'b1, 1'b1, 1'b0, lane(0, {8{8'h80}}));
        push_b(40'h00_0000_00FF, 25'd1);
        drive(1'b1, 1'b1, 1'b0, lane(0, 64'h90909090_90817F80));
        drive(1'b1, 1'b1, 1'b0, lane(0, {8{8'h80}}));
        drive(1'b1, 1'b1, 1'b0, lane(0, {8{8'h80}}));
        push_b(40'h00_0000_007F, 25'd1);
        idle(6);

        // 20@e5, 50@e2, 50@e7 with gaps: beat1 keeps the tie -> idx 10; lane2 0x7F at beat2 e0 -> idx 16
        drive(1'b1, 1'b1, 1'b0, lane(0, 64'h01011401_01010101));
        idle(1);
        drive(1'b1, 1'b1, 1'b0, lane(0, 64'h01010101_01320101));
        idle(2);
        drive(1'b1, 1'b1, 1'b0, lane(0, 64'h32010101_01010101) | lane(2, 64'h7F));
        push_b(40'h00_007F_0032, 25'd16394);
        idle(6);

        // Partial group flushed by finish together with its third beat
        drive(1'b1, 1'b1, 1'b0, lane(0, 64'h70));
        drive(1'b1, 1'b1, 1'b0, lane(0, 64'h70));
        drive(1'b1, 1'b1, 1'b1, lane(0, 64'h7E));
        idle(8);
        cmp("b hold value after finish", {24'd0, if_b.max_value}, 64'h00_007F_0032);
        cmp("b hold index after finish", {39'd0, if_b.max_index}, 64'd16394);

        // Fresh group restarts at beat 0
        drive(1'b1, 1'b1, 1'b0, lane(0, 64'h00000000_40000000));
        drive(1'b1, 1'b1, 1'b0, lane(0, {8{8'h10}}));
        drive(1'b1, 1'b1, 1'b0, lane(0, {8{8'h10}}));
        push_b(40'h00_0000_0040, 25'd3);
        idle(6);

        // Asynchronous reset between edges with a beat in flight
        drive(1'b0, 1'b1, 1'b0, lane(0, 64'h55));
        @(posedge clk);
        #1;
        if_a.in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        cmp("a async rst out_valid", {63'd0, if_a.out_valid}, 64'd0);
        cmp("a async rst max_value", {24'd0, if_a.max_value}, 64'd0);
        cmp("a async rst max_index", {49'd0, if_a.max_index}, 64'd0);
        cmp("b async rst max_value", {24'd0, if_b.max_value}, 64'd0);
        cmp("b async rst max_index", {39'd0, if_b.max_index}, 64'd0);
        #3;
        rst = 1'b1;
        idle(8);
        cmp("a no result after rst", {24'd0, if_a.max_value}, 64'd0);

        idle(4);
        cmp("a expectations drained", 64'(q_a.size()), 64'd0);
        cmp("b expectations drained", 64'(q_b.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
